// File: rtl/ball_overlay.sv
`timescale 1ns/1ps
// Sprite overlay for a raster pixel stream: positions a SPR_W x SPR_H sprite
// over the background, pulls sprite pixels from an external reader through
// o_en, and alpha-keys them onto the background with one cycle of latency.
module ball_overlay #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int SPR_W = 200,
    parameter int SPR_H = 200
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_start,
    input  logic               i_valid,
    input  logic [10:0]        i_x,
    input  logic [10:0]        i_y,
    input  logic [23:0]        i_bg_rgb,
    input  logic signed [11:0] i_pos_x,
    input  logic signed [11:0] i_pos_y,
    input  logic [31:0]        i_sprite_q,
    output logic               o_refresh,
    output logic signed [12:0] o_bias,
    output logic               o_en,
    output logic [23:0]        o_rgb,
    output logic               o_valid
);
    localparam int CW = $clog2(SPR_W);

    // All coordinate math is 13-bit signed so sums such as py+SPR_H never wrap.
    localparam logic signed [12:0] PX_MAX = 13'(H_ACT - SPR_W);
    localparam logic signed [12:0] PY_MIN = 13'(-(SPR_H - 1));
    localparam logic signed [12:0] PY_MAX = 13'(V_ACT - 1);
    localparam logic signed [12:0] SW     = 13'(SPR_W);
    localparam logic signed [12:0] SH     = 13'(SPR_H);
    localparam logic signed [12:0] VA     = 13'(V_ACT);

    typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DONE} state_t;

    state_t                state_q, state_d;
    logic signed [12:0]    px_q, px_d;
    logic signed [12:0]    py_q, py_d;
    logic signed [12:0]    rem_q, rem_d;
    logic signed [12:0]    bias_q, bias_d;
    logic [CW-1:0]         col_q, col_d;
    logic [23:0]           rgb_q;
    logic                  valid_q;

    logic signed [12:0]    pos_x_ext, pos_y_ext;
    logic signed [12:0]    px_clamp, py_clamp;
    logic signed [12:0]    x_ext, y_ext;
    logic signed [12:0]    ytop, ybot, ysum;
    logic signed [12:0]    arm_bias;
    logic                  hit;
    logic                  unused_sprite_bits;

    assign pos_x_ext = {i_pos_x[11], i_pos_x};
    assign pos_y_ext = {i_pos_y[11], i_pos_y};
    assign x_ext     = {2'b00, i_x};
    assign y_ext     = {2'b00, i_y};
    // Only the alpha MSB decides opacity; the rest of the alpha byte is ignored.
    assign unused_sprite_bits = ^i_sprite_q[6:0];

    // Clamp the requested corner so every sprite row lies fully on-screen
    // horizontally, and at least one row is visible vertically.
    always_comb begin
        px_clamp = pos_x_ext;
        if (pos_x_ext < 13'sd0)
            px_clamp = 13'sd0;
        else if (pos_x_ext > PX_MAX)
            px_clamp = PX_MAX;
        py_clamp = pos_y_ext;
        if (pos_y_ext < PY_MIN)
            py_clamp = PY_MIN;
        else if (pos_y_ext > PY_MAX)
            py_clamp = PY_MAX;
    end

    // Visible row window of the latched sprite position and the reader skip count.
    always_comb begin
        ysum     = py_q + SH;
        ytop     = (py_q < 13'sd0) ? 13'sd0 : py_q;
        ybot     = (ysum > VA) ? VA : ysum;
        arm_bias = (py_q < 13'sd0) ? -py_q : 13'sd0;
        hit      = (state_q == ACTIVE) && i_valid &&
                   (x_ext >= px_q) && (x_ext < px_q + SW) &&
                   (y_ext >= ytop) && (y_ext < ybot);
    end

    assign o_refresh = (state_q == ARM);
    assign o_bias    = (state_q == ARM) ? arm_bias : bias_q;
    assign o_en      = hit & ~i_rst;
    assign o_rgb     = rgb_q;
    assign o_valid   = valid_q;

    // Next-state logic: frame sequencing plus column/row bookkeeping per fetched pixel.
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        rem_d   = rem_q;
        bias_d  = bias_q;
        col_d   = col_q;
        case (state_q)
            ARM: begin
                state_d = ACTIVE;
                rem_d   = ybot - ytop;
                col_d   = '0;
                bias_d  = arm_bias;
            end
            ACTIVE: begin
                if (rem_q <= 13'sd0) begin
                    state_d = DONE;
                end else if (hit) begin
                    if (col_q == CW'(SPR_W - 1)) begin
                        col_d = '0;
                        rem_d = rem_q - 13'sd1;
                        if (rem_q == 13'sd1)
                            state_d = DONE;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase
        // A new frame always wins and abandons whatever was in progress.
        if (i_frame_start) begin
            state_d = ARM;
            px_d    = px_clamp;
            py_d    = py_clamp;
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            px_q    <= '0;
            py_q    <= '0;
            rem_q   <= '0;
            bias_q  <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            rem_q   <= rem_d;
            bias_q  <= bias_d;
            col_q   <= col_d;
        end
    end

    // One-cycle compositing stage: opaque sprite pixels replace the background.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rgb_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= i_valid;
            rgb_q   <= (hit && i_sprite_q[7]) ? i_sprite_q[31:8] : i_bg_rgb;
        end
    end
endmodule

// File: tb/tb_ball_overlay.sv
`timescale 1ns/1ps
// Bench for ball_overlay using a reduced raster so whole frames stay short.
module tb_ball_overlay;
    localparam int H  = 64;
    localparam int V  = 48;
    localparam int SW = 20;
    localparam int SH = 16;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_frame_start = 1'b0;
    logic               i_valid = 1'b0;
    logic [10:0]        i_x = '0;
    logic [10:0]        i_y = '0;
    logic [23:0]        i_bg_rgb = '0;
    logic signed [11:0] i_pos_x = '0;
    logic signed [11:0] i_pos_y = '0;
    logic [31:0]        i_sprite_q = '0;
    logic               o_refresh;
    logic signed [12:0] o_bias;
    logic               o_en;
    logic [23:0]        o_rgb;
    logic               o_valid;

    ball_overlay #(.H_ACT(H), .V_ACT(V), .SPR_W(SW), .SPR_H(SH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start),
        .i_valid(i_valid), .i_x(i_x), .i_y(i_y), .i_bg_rgb(i_bg_rgb),
        .i_pos_x(i_pos_x), .i_pos_y(i_pos_y), .i_sprite_q(i_sprite_q),
        .o_refresh(o_refresh), .o_bias(o_bias), .o_en(o_en),
        .o_rgb(o_rgb), .o_valid(o_valid)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    bit checking_on = 1'b0;
    int en_count = 0;
    int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    int gap_pct = 5;

    // Reference model: phase 0 idle, 1 arm, 2 run (run with cnt>=total means finished).
    int m_phase = 0, m_px = 0, m_ytop = 0, m_ybot = 0, m_cnt = 0, m_total = 0, m_bias = 0;
    bit m_ov = 1'b0;
    logic [23:0] m_rgb = '0;

    function automatic int clamp_x(input int p);
        return (p < 0) ? 0 : (p > H - SW) ? H - SW : p;
    endfunction
    function automatic int clamp_y(input int p);
        return (p < -(SH - 1)) ? -(SH - 1) : (p > V - 1) ? V - 1 : p;
    endfunction
    function automatic int ytop_of(input int py);
        return (py < 0) ? 0 : py;
    endfunction
    function automatic int ybot_of(input int py);
        return (py + SH > V) ? V : py + SH;
    endfunction
    function automatic int bias_of(input int py);
        return (py < 0) ? -py : 0;
    endfunction

    function automatic bit model_hit();
        return (m_phase == 2) && i_valid &&
               (int'(i_x) >= m_px) && (int'(i_x) < m_px + SW) &&
               (int'(i_y) >= m_ytop) && (int'(i_y) < m_ybot) && (m_cnt < m_total);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each active edge.
    always @(posedge i_clk) begin
        if (i_rst) begin
            m_phase <= 0; m_bias <= 0; m_ov <= 1'b0; m_rgb <= '0; m_cnt <= 0;
        end else begin
            m_ov  <= i_valid;
            m_rgb <= (model_hit() && i_sprite_q[7]) ? i_sprite_q[31:8] : i_bg_rgb;
            if (i_frame_start) begin
                m_phase <= 1;
                m_px    <= clamp_x(int'(i_pos_x));
                m_ytop  <= ytop_of(clamp_y(int'(i_pos_y)));
                m_ybot  <= ybot_of(clamp_y(int'(i_pos_y)));
                m_total <= SW * (ybot_of(clamp_y(int'(i_pos_y))) - ytop_of(clamp_y(int'(i_pos_y))));
                m_bias  <= bias_of(clamp_y(int'(i_pos_y)));
                m_cnt   <= 0;
            end else begin
                if (model_hit()) m_cnt <= m_cnt + 1;
                if (m_phase == 1) m_phase <= 2;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge i_clk) begin
        if (checking_on) begin
            if (!i_rst) chk("refresh", int'(o_refresh), int'(m_phase == 1));
            chk("en", int'(o_en), int'(!i_rst && model_hit()));
            chk("bias", int'(o_bias), m_bias);
            chk("valid", int'(o_valid), int'(m_ov));
            if (m_ov) chk("rgb", int'(o_rgb), int'(m_rgb));
            if (o_en) begin
                en_count++;
                if (en_count == 1) begin
                    first_x = int'(i_x);
                    first_y = int'(i_y);
                end
                last_x = int'(i_x);
                last_y = int'(i_y);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_pix(input int x, input int y, input logic [23:0] bg, input logic [31:0] q);
        i_valid = 1'b1; i_x = 11'(x); i_y = 11'(y); i_bg_rgb = bg; i_sprite_q = q;
        tick();
    endtask

    task automatic pixels(input int from, input int upto);
        for (int n = from; n < upto; n++) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                i_valid = 1'b0;
                tick();
            end
            drive_pix(n % H, n / H, 24'($urandom), $urandom);
        end
        i_valid = 1'b0;
    endtask

    task automatic start_frame(input int x, input int y, input int exp_bias, input bit arm_valid);
        i_pos_x = 12'(x); i_pos_y = 12'(y);
        i_frame_start = 1'b1; i_valid = 1'b0;
        tick();
        i_frame_start = 1'b0;
        en_count = 0; first_x = -1; first_y = -1;
        chk("arm_refresh", int'(o_refresh), 1);
        chk("arm_bias", int'(o_bias), exp_bias);
        if (arm_valid) begin
            i_valid = 1'b1;
            i_x = 11'(clamp_x(x));
            i_y = 11'(ytop_of(clamp_y(y)));
            #1;
            chk("arm_no_en", int'(o_en), 0);
        end
        tick();
        i_valid = 1'b0;
        chk("post_arm_refresh", int'(o_refresh), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int rx, ry, py;
        tick();
        checking_on = 1'b1;
        tick(); tick();
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_rgb", int'(o_rgb), 0);
        chk("rst_refresh", int'(o_refresh), 0);
        chk("rst_bias", int'(o_bias), 0);
        i_rst = 1'b0;
        tick();

        // Nominal sprite with fixed-colour alpha checks at its first two pixels.
        start_frame(10, 5, 0, 1'b0);
        pixels(0, 5 * H + 10);
        drive_pix(10, 5, 24'h00FF00, 32'hFF000080);
        chk("rgb_opaque", int'(o_rgb), 24'hFF0000);
        drive_pix(11, 5, 24'h00FF00, 32'hFF000000);
        chk("rgb_transparent", int'(o_rgb), 24'h00FF00);
        pixels(5 * H + 12, H * V);
        tick();
        chk("A_pulses", en_count, 320);
        chk("A_first_x", first_x, 10);
        chk("A_first_y", first_y, 5);
        chk("A_last_x", last_x, 29);
        chk("A_last_y", last_y, 20);

        // Sprite partly above the screen.
        start_frame(10, -3, 3, 1'b0);
        pixels(0, H * V);
        tick();
        chk("B_pulses", en_count, 260);
        chk("B_first_y", first_y, 0);
        chk("B_last_y", last_y, 12);

        // Sprite clamped right and cut at the bottom.
        start_frame(50, 40, 0, 1'b0);
        pixels(0, H * V);
        tick();
        chk("C_pulses", en_count, 160);
        chk("C_first_x", first_x, 44);
        chk("C_first_y", first_y, 40);

        // Reset in the middle of a sprite.
        start_frame(10, 5, 0, 1'b0);
        pixels(0, 8 * H + 15);
        i_rst = 1'b1; i_valid = 1'b1; i_x = 11'd15; i_y = 11'd8;
        #1;
        chk("midrst_en", int'(o_en), 0);
        tick();
        i_rst = 1'b0;
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_rgb", int'(o_rgb), 0);
        en_count = 0;
        pixels(8 * H + 16, H * V);
        tick();
        chk("midrst_no_en", en_count, 0);
        start_frame(10, -3, 3, 1'b0);
        pixels(0, H * V);
        tick();
        chk("D_pulses", en_count, 260);

        // Frame start re-issued while a sprite is being fetched.
        start_frame(10, 5, 0, 1'b0);
        pixels(0, 10 * H + 12);
        start_frame(0, 0, 0, 1'b1);
        pixels(0, H * V);
        tick();
        chk("E_pulses", en_count, 320);
        chk("E_first_x", first_x, 0);
        chk("E_first_y", first_y, 0);

        // Reset and frame start together: reset wins.
        i_rst = 1'b1; i_frame_start = 1'b1; i_pos_x = '0; i_pos_y = '0;
        tick();
        i_rst = 1'b0; i_frame_start = 1'b0;
        chk("rstwins_refresh", int'(o_refresh), 0);
        en_count = 0;
        pixels(0, 2 * H);
        tick();
        chk("rstwins_no_en", en_count, 0);

        // Extreme requested corner.
        start_frame(-2048, 2047, 0, 1'b0);
        pixels(0, H * V);
        tick();
        chk("G_pulses", en_count, 20);
        chk("G_first_y", first_y, 47);

        // Randomized positions, including off-screen requests.
        for (int f = 0; f < 4; f++) begin
            rx = int'($urandom_range(0, 120)) - 40;
            ry = int'($urandom_range(0, 90)) - 40;
            py = clamp_y(ry);
            start_frame(rx, ry, bias_of(py), 1'b0);
            pixels(0, H * V);
            tick();
            chk("R_pulses", en_count, SW * (ybot_of(py) - ytop_of(py)));
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
